// File: rtl/serial_operand_feeder.sv
// Upstream stage of a bit-serial adder: captures two parallel operands and
// emits them one bit pair per clock, LSB first, then one zero pair to drain the carry.
module serial_operand_feeder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             LOAD_VALID,
    output logic             LOAD_READY,
    input  logic [WIDTH-1:0] OP_A,
    input  logic [WIDTH-1:0] OP_B,
    input  logic             ABORT,
    output logic             A_BIT,
    output logic             B_BIT,
    output logic             BIT_VALID,
    output logic             FIRST,
    output logic             LAST,
    output logic             BUSY,
    output logic             DONE
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StShift = 2'b01,
        StFlush = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  sh_a_q, sh_a_d;
    logic [WIDTH-1:0]  sh_b_q, sh_b_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              last_bit;

    assign last_bit = (cnt_q == LastCnt);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= StIdle;
            sh_a_q  <= '0;
            sh_b_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sh_a_q  <= sh_a_d;
            sh_b_q  <= sh_b_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: every exit to IDLE clears the datapath so nothing stale leaks out.
    always_comb begin
        state_d = state_q;
        sh_a_d  = sh_a_q;
        sh_b_d  = sh_b_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (LOAD_VALID && !ABORT) begin
                    sh_a_d  = OP_A;
                    sh_b_d  = OP_B;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (ABORT) begin
                    sh_a_d  = '0;
                    sh_b_d  = '0;
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    sh_a_d = sh_a_q >> 1;
                    sh_b_d = sh_b_q >> 1;
                    cnt_d  = cnt_q + CntW'(1);
                    if (last_bit) begin
                        state_d = StFlush;
                    end
                end
            end
            StFlush: begin
                sh_a_d  = '0;
                sh_b_d  = '0;
                cnt_d   = '0;
                state_d = StIdle;
            end
            default: begin
                sh_a_d  = '0;
                sh_b_d  = '0;
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decode registered state only; no input reaches an output combinationally.
    always_comb begin
        LOAD_READY = 1'b0;
        A_BIT      = 1'b0;
        B_BIT      = 1'b0;
        BIT_VALID  = 1'b0;
        FIRST      = 1'b0;
        LAST       = 1'b0;
        BUSY       = 1'b0;
        DONE       = 1'b0;
        unique case (state_q)
            StIdle: begin
                LOAD_READY = 1'b1;
            end
            StShift: begin
                A_BIT     = sh_a_q[0];
                B_BIT     = sh_b_q[0];
                BIT_VALID = 1'b1;
                BUSY      = 1'b1;
                FIRST     = (cnt_q == '0);
                LAST      = last_bit;
            end
            StFlush: begin
                BUSY = 1'b1;
                DONE = 1'b1;
            end
            default: begin
                LOAD_READY = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_operand_feeder.sv
// Directed plus randomized bench for serial_operand_feeder; expected bits come from
// operand indexing and expected sums from plain addition.
module tb_serial_operand_feeder;

    localparam int unsigned W = 8;

    logic         CLK;
    logic         RST;
    logic         LOAD_VALID;
    logic         LOAD_READY;
    logic [W-1:0] OP_A;
    logic [W-1:0] OP_B;
    logic         ABORT;
    logic         A_BIT;
    logic         B_BIT;
    logic         BIT_VALID;
    logic         FIRST;
    logic         LAST;
    logic         BUSY;
    logic         DONE;

    int checks = 0;
    int errors = 0;

    serial_operand_feeder #(.WIDTH(W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .LOAD_VALID(LOAD_VALID),
        .LOAD_READY(LOAD_READY),
        .OP_A      (OP_A),
        .OP_B      (OP_B),
        .ABORT     (ABORT),
        .A_BIT     (A_BIT),
        .B_BIT     (B_BIT),
        .BIT_VALID (BIT_VALID),
        .FIRST     (FIRST),
        .LAST      (LAST),
        .BUSY      (BUSY),
        .DONE      (DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check_bit({tag, "_ready"}, LOAD_READY, 1'b1);
        check_bit({tag, "_valid"}, BIT_VALID, 1'b0);
        check_bit({tag, "_busy"}, BUSY, 1'b0);
        check_bit({tag, "_done"}, DONE, 1'b0);
        check_bit({tag, "_a"}, A_BIT, 1'b0);
        check_bit({tag, "_b"}, B_BIT, 1'b0);
        check_bit({tag, "_first"}, FIRST, 1'b0);
        check_bit({tag, "_last"}, LAST, 1'b0);
    endtask

    task automatic check_shift(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        check_bit("shift_a", A_BIT, a[i]);
        check_bit("shift_b", B_BIT, b[i]);
        check_bit("shift_valid", BIT_VALID, 1'b1);
        check_bit("shift_busy", BUSY, 1'b1);
        check_bit("shift_first", FIRST, i == 0);
        check_bit("shift_last", LAST, i == int'(W) - 1);
        check_bit("shift_done", DONE, 1'b0);
        check_bit("shift_ready", LOAD_READY, 1'b0);
    endtask

    // Starts at a negedge in IDLE; returns at the negedge of the first SHIFT cycle.
    task automatic load(input logic [W-1:0] a, input logic [W-1:0] b);
        check_bit("load_ready", LOAD_READY, 1'b1);
        OP_A       = a;
        OP_B       = b;
        LOAD_VALID = 1'b1;
        @(negedge CLK);
        LOAD_VALID = 1'b0;
        OP_A       = W'($urandom);
        OP_B       = W'($urandom);
    endtask

    // Full operation with a downstream serial adder summing the emitted bits.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
        logic         carry;
        logic [W:0]   sum;
        carry = 1'b0;
        sum   = '0;
        load(a, b);
        for (int i = 0; i < int'(W); i++) begin
            check_shift(i, a, b);
            sum[i] = A_BIT ^ B_BIT ^ carry;
            carry  = (A_BIT & B_BIT) | (carry & (A_BIT ^ B_BIT));
            @(negedge CLK);
        end
        check_bit("flush_done", DONE, 1'b1);
        check_bit("flush_busy", BUSY, 1'b1);
        check_bit("flush_valid", BIT_VALID, 1'b0);
        check_bit("flush_ready", LOAD_READY, 1'b0);
        check_bit("flush_a", A_BIT, 1'b0);
        check_bit("flush_b", B_BIT, 1'b0);
        check_bit("flush_first", FIRST, 1'b0);
        check_bit("flush_last", LAST, 1'b0);
        sum[W] = A_BIT ^ B_BIT ^ carry;
        check_val("adder_sum", 32'(sum), 32'(a) + 32'(b));
        @(negedge CLK);
        check_idle("post_op");
    endtask

    initial begin
        logic [W-1:0] cap_a;
        logic [W-1:0] cap_b;
        int           p;
        RST        = 1'b0;
        LOAD_VALID = 1'b0;
        ABORT      = 1'b0;
        OP_A       = '0;
        OP_B       = '0;
        cap_a      = '0;
        cap_b      = '0;

        @(negedge CLK);
        check_idle("in_reset");
        @(negedge CLK);
        RST = 1'b1;

        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            check_idle("reset_idle");
        end

        run_op(8'h5A, 8'h3C);
        run_op(8'hFF, 8'hFF);
        run_op(8'h00, 8'h00);
        for (int n = 0; n < 10; n++) begin
            run_op(W'($urandom), W'($urandom));
        end

        // LOAD_VALID held high: transfers only every W+2 cycles.
        for (int c = 0; c < 30; c++) begin
            p = c % (int'(W) + 2);
            if (p == 0) begin
                check_idle("held_idle");
            end else if (p <= int'(W)) begin
                check_shift(p - 1, cap_a, cap_b);
            end else begin
                check_bit("held_done", DONE, 1'b1);
                check_bit("held_ready", LOAD_READY, 1'b0);
            end
            OP_A       = W'($urandom);
            OP_B       = W'($urandom);
            LOAD_VALID = 1'b1;
            if (p == 0) begin
                cap_a = OP_A;
                cap_b = OP_B;
            end
            @(negedge CLK);
        end
        check_idle("held_end");
        LOAD_VALID = 1'b0;
        @(negedge CLK);
        check_idle("held_after");

        // ABORT at bit 3.
        cap_a = W'($urandom) | 8'h80;
        cap_b = W'($urandom);
        load(cap_a, cap_b);
        for (int i = 0; i < 4; i++) begin
            check_shift(i, cap_a, cap_b);
            if (i == 3) ABORT = 1'b1;
            @(negedge CLK);
        end
        ABORT = 1'b0;
        check_idle("abort_next");
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            check_idle("abort_quiet");
        end

        // ABORT wins over LOAD_VALID in IDLE.
        LOAD_VALID = 1'b1;
        ABORT      = 1'b1;
        OP_A       = 8'hAA;
        OP_B       = 8'h55;
        @(negedge CLK);
        LOAD_VALID = 1'b0;
        ABORT      = 1'b0;
        check_idle("abort_idle");
        run_op(8'h01, 8'h01);

        // Asynchronous reset at bit 5.
        cap_a = 8'hFF;
        cap_b = 8'hE0;
        load(cap_a, cap_b);
        for (int i = 0; i < 6; i++) begin
            check_shift(i, cap_a, cap_b);
            if (i < 5) @(negedge CLK);
        end
        #2;
        RST = 1'b0;
        #1;
        check_idle("async_reset");
        @(negedge CLK);
        check_idle("reset_held");
        RST = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge CLK);
            check_idle("reset_quiet");
        end

        run_op(W'($urandom), W'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
